i2s_master_ctrl: RTL and testbench

- Master-side controller for the I2S receive path.
- Generates the bit clock and word clock (`bclk`, `wclk`) from `sysclk` and sequences start/stop so only whole frames are produced.
- Collects each stereo pair flagged by the receiver's `rec_clk` pulse into a one-entry valid/ready output buffer, with sticky overrun detection.
- Sits between the external codec/ADC pins, the I2S receiver and the downstream audio consumer.

---
 rtl/i2s_pkg.sv | 19 +
 rtl/i2s_clkgen.sv | 77 +++++++
 rtl/i2s_master_ctrl.sv | 148 ++++++++++++++
 tb/tb_i2s_master_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S master controller.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int DEF_BCLK_DIV    = 4;
  localparam int DEF_BITS_PER_CH = 16;
  localparam int DEF_DATA_W      = 16;

  // Width of the half-period counter that counts 0..div-1.
  function automatic int half_cnt_w(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Bit clock / word clock generator with frame strobe and wrap report.
// While clk_en is low every counter and clock output is held at 0, so a
// fresh RUN always starts from slot 0 with bclk low.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV    = DEF_BCLK_DIV,
  parameter int BITS_PER_CH = DEF_BITS_PER_CH
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,       // clocking active (RUN or STOP)
  input  logic start,        // leaving IDLE this cycle: strobe the first frame
  input  logic stop_req,     // a wrap this cycle ends clocking: no strobe
  output logic bclk,
  output logic wclk,
  output logic frame_strobe,
  output logic wrap          // last slot ends this cycle
);

  localparam int HW    = half_cnt_w(BCLK_DIV);
  localparam int SLOTS = 2 * BITS_PER_CH;
  localparam int BW    = (SLOTS <= 2) ? 1 : $clog2(SLOTS);

  localparam logic [HW-1:0] HALF_LAST = HW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(SLOTS - 1);
  localparam logic [BW-1:0] BIT_RIGHT = BW'(BITS_PER_CH);

  logic [HW-1:0] half_q;
  logic [BW-1:0] bit_q;
  logic [BW-1:0] bit_next;
  logic          bclk_q;
  logic          wclk_q;
  logic          strobe_q;
  logic          half_end;
  logic          bclk_fall;

  // Decode half-period end, bclk falling toggle, next slot and frame wrap.
  always_comb begin
    half_end  = clk_en && (half_q == HALF_LAST);
    bclk_fall = half_end && bclk_q;
    bit_next  = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
    wrap      = bclk_fall && (bit_q == BIT_LAST);
  end

  // Counters and registered clock / strobe outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q   <= '0;
      bit_q    <= '0;
      bclk_q   <= 1'b0;
      wclk_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else if (!clk_en) begin
      half_q   <= '0;
      bit_q    <= '0;
      bclk_q   <= 1'b0;
      wclk_q   <= 1'b0;
      strobe_q <= start;
    end else begin
      half_q <= half_end ? '0 : half_q + 1'b1;
      if (half_end) begin
        bclk_q <= ~bclk_q;
      end
      if (bclk_fall) begin
        bit_q  <= bit_next;
        wclk_q <= (bit_next >= BIT_RIGHT);
      end
      strobe_q <= wrap && !stop_req;
    end
  end

  assign bclk         = bclk_q;
  assign wclk         = wclk_q;
  assign frame_strobe = strobe_q;

endmodule

// File: rtl/i2s_master_ctrl.sv
// I2S receive-path master: start/stop sequencing on whole frames plus a
// one-entry valid/ready buffer for received stereo pairs.
// Handshake: a pair is transferred on any sysclk edge where sample_valid
// and sample_ready are both high; sample_left/right are stable while
// sample_valid is high and not yet transferred.
module i2s_master_ctrl
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV    = DEF_BCLK_DIV,
  parameter int BITS_PER_CH = DEF_BITS_PER_CH,
  parameter int DATA_W      = DEF_DATA_W
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              enable,
  output logic              bclk,
  output logic              wclk,
  output logic              running,
  output logic              frame_strobe,
  input  logic [DATA_W-1:0] rx_left,
  input  logic [DATA_W-1:0] rx_right,
  input  logic              rx_rec_clk,
  output logic [DATA_W-1:0] sample_left,
  output logic [DATA_W-1:0] sample_right,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  input  logic              clr_overrun,
  output state_t            dbg_state
);

  state_t state_q;
  logic   running_q;
  logic   wrap;
  logic   clk_en;
  logic   start;
  logic   stop_req;

  // Clocking is live outside IDLE; a wrap only ends clocking in STOP with
  // enable still low (enable high in STOP resumes RUN without a gap).
  always_comb begin
    clk_en   = (state_q != IDLE);
    start    = (state_q == IDLE) && enable;
    stop_req = (state_q == STOP) && !enable;
  end

  i2s_clkgen #(
    .BCLK_DIV    (BCLK_DIV),
    .BITS_PER_CH (BITS_PER_CH)
  ) u_clkgen (
    .clk          (sysclk),
    .rst          (rst),
    .clk_en       (clk_en),
    .start        (start),
    .stop_req     (stop_req),
    .bclk         (bclk),
    .wclk         (wclk),
    .frame_strobe (frame_strobe),
    .wrap         (wrap)
  );

  // Run/stop state machine with registered running flag.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) begin
            state_q <= STOP;
          end
        end
        STOP: begin
          if (enable) begin
            state_q <= RUN;
          end else if (wrap) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign running   = running_q;
  assign dbg_state = state_q;

  logic [DATA_W-1:0] left_q, left_d;
  logic [DATA_W-1:0] right_q, right_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  logic              consume;

  // Buffer next state: load when empty or draining, else drop and flag.
  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    consume = valid_q && sample_ready;
    if (clr_overrun) begin
      ovr_d = 1'b0;
    end
    if (rx_rec_clk) begin
      if (!valid_q || consume) begin
        left_d  = rx_left;
        right_d = rx_right;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  // Buffer registers.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      left_q  <= left_d;
      right_q <= right_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sample_left  = left_q;
  assign sample_right = right_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_i2s_master_ctrl.sv
// Self-checking bench for i2s_master_ctrl with a cycle-arithmetic model.
module tb_i2s_master_ctrl;
  import i2s_pkg::*;

  localparam int DIV = 2;
  localparam int N   = 16;
  localparam int W   = 16;
  localparam int F   = 2 * DIV * 2 * N;   // sysclk cycles per frame

  // ---------------- clock / reset ----------------
  logic sysclk = 1'b0;
  logic rst    = 1'b1;
  always #5 sysclk = ~sysclk;

  logic         enable = 1'b0;
  logic         bclk, wclk, running, frame_strobe;
  logic [W-1:0] rx_left = '0, rx_right = '0;
  logic         rx_rec_clk = 1'b0;
  logic [W-1:0] sample_left, sample_right;
  logic         sample_valid;
  logic         sample_ready = 1'b0;
  logic         overrun;
  logic         clr_overrun = 1'b0;
  state_t       dbg_state;

  i2s_master_ctrl #(
    .BCLK_DIV    (DIV),
    .BITS_PER_CH (N),
    .DATA_W      (W)
  ) dut (
    .sysclk       (sysclk),
    .rst          (rst),
    .enable       (enable),
    .bclk         (bclk),
    .wclk         (wclk),
    .running      (running),
    .frame_strobe (frame_strobe),
    .rx_left      (rx_left),
    .rx_right     (rx_right),
    .rx_rec_clk   (rx_rec_clk),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .clr_overrun  (clr_overrun),
    .dbg_state    (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Clocking is described purely by t = cycles since leaving IDLE.
  bit            m_run  = 0;
  bit            m_stop = 0;
  int            m_t    = 0;
  bit            m_valid = 0;
  bit            m_ovr   = 0;
  logic [W-1:0]  m_l = '0, m_r = '0;
  logic [2*W-1:0] exp_q[$];

  function automatic int m_slot();
    return (m_t / (2 * DIV)) % (2 * N);
  endfunction

  task automatic model_update();
    bit cons;
    if (rst) begin
      m_run = 0; m_stop = 0; m_t = 0;
      m_valid = 0; m_ovr = 0; m_l = '0; m_r = '0;
      exp_q.delete();
      return;
    end
    if (!m_run) begin
      if (enable) begin
        m_run = 1; m_t = 0; m_stop = 0;
      end
    end else if (m_stop && !enable && ((m_t + 1) % F == 0)) begin
      m_run = 0; m_stop = 0; m_t = 0;
    end else begin
      m_t++;
      m_stop = !enable;
    end
    cons = m_valid && sample_ready;
    if (clr_overrun) m_ovr = 0;
    if (rx_rec_clk) begin
      if (!m_valid || cons) begin
        m_l = rx_left; m_r = rx_right; m_valid = 1;
        exp_q.push_back({rx_left, rx_right});
      end else begin
        m_ovr = 1;
      end
    end else if (cons) begin
      m_valid = 0;
    end
  endtask

  task automatic check_all();
    check_eq("bclk", bclk, m_run ? ((m_t / DIV) % 2) : 0);
    check_eq("wclk", wclk, m_run ? (m_slot() >= N) : 0);
    check_eq("frame_strobe", frame_strobe, m_run ? (m_t % F == 0) : 0);
    check_eq("running", running, m_run);
    check_eq("state_active", dbg_state != IDLE, m_run);
    check_eq("sample_valid", sample_valid, m_valid);
    check_eq("overrun", overrun, m_ovr);
    if (m_valid) begin
      check_eq("hold_left", sample_left, m_l);
      check_eq("hold_right", sample_right, m_r);
    end
  endtask

  // One cycle: score a pending transfer, clock edge, model, then check.
  task automatic step();
    logic [2*W-1:0] e;
    if (sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_pair", {sample_left, sample_right}, e);
      end
    end
    @(posedge sysclk);
    model_update();
    @(negedge sysclk);
    check_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) step();
    check_eq("rst_state", dbg_state, IDLE);
    check_eq("rst_left", sample_left, 0);
    rst = 1'b0;
    repeat (10) step();

    // Continuous run for two frames, then reset in slot 10.
    enable = 1'b1;
    repeat (2 * F) step();
    for (int i = 0; i < 2 * F && !(m_run && m_slot() == 10); i++) step();
    check_eq("reach_slot10", m_run && m_slot() == 10, 1);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_bclk", bclk, 0);
    check_eq("arst_wclk", wclk, 0);
    check_eq("arst_running", running, 0);
    check_eq("arst_strobe", frame_strobe, 0);
    check_eq("arst_state", dbg_state, IDLE);
    enable = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    repeat (20) step();

    // Stop requested in slot 5: finish the frame, then idle.
    enable = 1'b1;
    step();
    for (int i = 0; i < 2 * F && !(m_slot() == 5); i++) step();
    enable = 1'b0;
    for (int i = 0; i < 2 * F && m_run; i++) step();
    check_eq("stop_idle", running, 0);
    repeat (F + 10) step();

    // Single pair held without ready, then consumed.
    rx_left = 16'h1234; rx_right = 16'hABCD; rx_rec_clk = 1'b1;
    step();
    rx_rec_clk = 1'b0;
    check_eq("pair_valid", sample_valid, 1);
    step();
    check_eq("pair_left", sample_left, 16'h1234);
    check_eq("pair_right", sample_right, 16'hABCD);
    sample_ready = 1'b1;
    step();
    sample_ready = 1'b0;
    check_eq("pair_drained", sample_valid, 0);

    // Overrun: second pair dropped, clear, then clear coincident with drop.
    rx_left = 16'h1234; rx_right = 16'hABCD; rx_rec_clk = 1'b1;
    step();
    rx_left = 16'h5555; rx_right = 16'h6666;
    step();
    rx_rec_clk = 1'b0;
    check_eq("ovr_set", overrun, 1);
    check_eq("ovr_keep_left", sample_left, 16'h1234);
    check_eq("ovr_keep_right", sample_right, 16'hABCD);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    check_eq("ovr_clr", overrun, 0);
    clr_overrun = 1'b1; rx_rec_clk = 1'b1; rx_left = 16'h7777;
    step();
    clr_overrun = 1'b0; rx_rec_clk = 1'b0;
    check_eq("ovr_set_wins", overrun, 1);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;

    // Load in the same cycle as consumption.
    rx_left = 16'h9999; rx_right = 16'h8888; rx_rec_clk = 1'b1; sample_ready = 1'b1;
    step();
    rx_rec_clk = 1'b0; sample_ready = 1'b0;
    check_eq("swap_valid", sample_valid, 1);
    check_eq("swap_left", sample_left, 16'h9999);
    check_eq("swap_ovr", overrun, 0);

    // Randomized traffic with enable toggling.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      rx_rec_clk   = ($urandom_range(0, 3) == 0);
      rx_left      = W'($urandom);
      rx_right     = W'($urandom);
      sample_ready = ($urandom_range(0, 1) == 0);
      clr_overrun  = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
